// File: rtl/gsm_fir_pkg.sv
// Shared constants, state encoding and wrap-around address helpers for the
// folded symmetric FIR MAC sequencer.
package gsm_fir_pkg;

  localparam int LENGTH  = 101;
  localparam int NTAPS   = (LENGTH + 1) / 2;
  localparam int AW      = 7;
  localparam int CW      = 6;
  localparam int MAC_LAT = 3;

  // Index of the unpaired centre tap, issued last.
  localparam logic [CW-1:0] CENTRE_K  = CW'(NTAPS - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(LENGTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Circular increment over 0..LENGTH-1 without a modulo operator.
  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + AW'(1);
  endfunction

  // Circular decrement over 0..LENGTH-1 without a modulo operator.
  function automatic logic [AW-1:0] addr_dec(input logic [AW-1:0] a);
    return (a == '0) ? LAST_ADDR : a - AW'(1);
  endfunction

endpackage

// File: rtl/gsm_ctrl_delay.sv
// Fixed-depth shift register that aligns issue-side control bits with the
// accumulator input of the MAC datapath.
module gsm_ctrl_delay #(
  parameter int DEPTH = 3,
  parameter int W     = 3
) (
  input  logic         sys_clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] pipe_q [DEPTH];

  // Shift control bits one stage per clock; reset flushes anything in flight.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/gsm_fir_mac_sequencer.sv
// Sequencer for a single folded pre-add/multiply/accumulate slice: writes each
// accepted sample into the circular sample RAM, then issues one symmetric tap
// pair per clock and flags the completed sum.
module gsm_fir_mac_sequencer
  import gsm_fir_pkg::*;
(
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          sam_clk_en,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  output logic [CW-1:0] coef_addr,
  output logic          pair_en,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          y_strobe,
  output logic          busy,
  output logic          overrun
);

  state_t        state, state_nxt;
  logic          wr_en_nxt;
  logic [AW-1:0] wr_addr_nxt, rd_a_nxt, rd_b_nxt;
  logic [CW-1:0] coef_nxt;
  logic          pair_nxt, vld_nxt, clr_nxt, last_nxt, busy_nxt, ovr_nxt;

  // wr_addr doubles as the write pointer: it always holds the newest sample slot.
  logic          issue_vld_p0, issue_clr_p0, issue_last_p0;
  logic [2:0]    ctrl_dly;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_nxt   = state;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr;
    rd_a_nxt    = '0;
    rd_b_nxt    = '0;
    coef_nxt    = '0;
    pair_nxt    = 1'b0;
    vld_nxt     = 1'b0;
    clr_nxt     = 1'b0;
    last_nxt    = 1'b0;
    ovr_nxt     = overrun | (sam_clk_en & (state != ST_IDLE));
    case (state)
      ST_IDLE: begin
        if (sam_clk_en) begin
          state_nxt   = ST_LOAD;
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = addr_inc(wr_addr);
        end
      end
      ST_LOAD: begin
        // First tap: newest sample against the oldest one still in the window.
        state_nxt = ST_RUN;
        coef_nxt  = '0;
        last_nxt  = (coef_nxt == CENTRE_K);
        pair_nxt  = ~last_nxt;
        rd_a_nxt  = wr_addr;
        rd_b_nxt  = last_nxt ? '0 : addr_inc(wr_addr);
        vld_nxt   = 1'b1;
        clr_nxt   = 1'b1;
      end
      ST_RUN: begin
        if (issue_last_p0) begin
          state_nxt = ST_IDLE;
        end else begin
          // a walks back in time, b walks forward, meeting at the centre tap.
          coef_nxt = coef_addr + CW'(1);
          last_nxt = (coef_nxt == CENTRE_K);
          pair_nxt = ~last_nxt;
          rd_a_nxt = addr_dec(rd_addr_a);
          rd_b_nxt = last_nxt ? '0 : addr_inc(rd_addr_b);
          vld_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State and issue-side output registers.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      rd_addr_a     <= '0;
      rd_addr_b     <= '0;
      coef_addr     <= '0;
      pair_en       <= 1'b0;
      issue_vld_p0  <= 1'b0;
      issue_clr_p0  <= 1'b0;
      issue_last_p0 <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state         <= state_nxt;
      wr_en         <= wr_en_nxt;
      wr_addr       <= wr_addr_nxt;
      rd_addr_a     <= rd_a_nxt;
      rd_addr_b     <= rd_b_nxt;
      coef_addr     <= coef_nxt;
      pair_en       <= pair_nxt;
      issue_vld_p0  <= vld_nxt;
      issue_clr_p0  <= clr_nxt;
      issue_last_p0 <= last_nxt;
      busy          <= busy_nxt;
      overrun       <= ovr_nxt;
    end
  end

  // Issue -> accumulator input: RAM read, pre-add and multiply latency.
  gsm_ctrl_delay #(
    .DEPTH (MAC_LAT),
    .W     (3)
  ) u_ctrl_delay (
    .sys_clk (sys_clk),
    .reset   (reset),
    .din     ({issue_vld_p0, issue_clr_p0, issue_last_p0}),
    .dout    (ctrl_dly)
  );

  assign acc_en  = ctrl_dly[2];
  assign acc_clr = ctrl_dly[1];

  // Accumulator input -> accumulator output: the sum is complete one cycle later.
  always_ff @(posedge sys_clk) begin
    if (reset) y_strobe <= 1'b0;
    else       y_strobe <= ctrl_dly[0];
  end

endmodule
